// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: handshaked pipeline register slice with flush, bubble control zeroing and a saturating stall counter.
// Define PIPE_STAGE_SKID_EN to add a skid entry so that in_ready_o becomes a registered output.
module pipe_stage_reg #(
   parameter int unsigned       DATA_W   = 128,
   parameter int unsigned       CTRL_W   = 8,
   parameter logic [CTRL_W-1:0] CTRL_RST = '0,
   parameter int unsigned       CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   input  logic [CTRL_W-1:0] in_ctrl_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [CTRL_W-1:0] out_ctrl_o,
   input  logic              cnt_clr_i,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   logic              main_valid;
   logic [DATA_W-1:0] main_data;
   logic [CTRL_W-1:0] main_ctrl;
   logic              accept;
   logic              emit;
   logic              stall;
   logic [CNT_W-1:0]  cnt;

   assign emit  = main_valid && out_ready_i;
   assign stall = main_valid && !out_ready_i;

`ifdef PIPE_STAGE_SKID_EN
   logic              skid_valid;
   logic [DATA_W-1:0] skid_data;
   logic [CTRL_W-1:0] skid_ctrl;

   assign in_ready_o = !skid_valid;
   assign accept     = in_valid_i && !skid_valid;

   // skid only fills while main is full and stalled, so main empty implies skid empty
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid <= 1'b0;
         main_data  <= '0;
         main_ctrl  <= CTRL_RST;
         skid_valid <= 1'b0;
         skid_data  <= '0;
         skid_ctrl  <= CTRL_RST;
      end else if (flush_i) begin
         main_valid <= 1'b0;
         main_ctrl  <= CTRL_RST;
         skid_valid <= 1'b0;
         skid_ctrl  <= CTRL_RST;
      end else if (!main_valid || emit) begin
         if (skid_valid) begin
            main_valid <= 1'b1;
            main_data  <= skid_data;
            main_ctrl  <= skid_ctrl;
            skid_valid <= 1'b0;
            skid_ctrl  <= CTRL_RST;
         end else if (accept) begin
            main_valid <= 1'b1;
            main_data  <= in_data_i;
            main_ctrl  <= in_ctrl_i;
         end else begin
            main_valid <= 1'b0;
            main_ctrl  <= CTRL_RST;
         end
      end else if (accept) begin
         skid_valid <= 1'b1;
         skid_data  <= in_data_i;
         skid_ctrl  <= in_ctrl_i;
      end
   end
`else
   assign in_ready_o = !main_valid || out_ready_i;
   assign accept     = in_valid_i && in_ready_o;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid <= 1'b0;
         main_data  <= '0;
         main_ctrl  <= CTRL_RST;
      end else if (flush_i) begin
         main_valid <= 1'b0;
         main_ctrl  <= CTRL_RST;
      end else if (accept) begin
         main_valid <= 1'b1;
         main_data  <= in_data_i;
         main_ctrl  <= in_ctrl_i;
      end else if (emit) begin
         main_valid <= 1'b0;
         main_ctrl  <= CTRL_RST;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (cnt_clr_i) begin
         cnt <= '0;
      end else if (stall && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign out_valid_o = main_valid;
   assign out_data_o  = main_data;
   assign out_ctrl_o  = main_ctrl;
   assign stall_cnt_o = cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (CNT_W=4, non-zero CTRL_RST); covers base and skid builds.
module tb_pipe_stage_reg;

   localparam int unsigned       DATA_W   = 128;
   localparam int unsigned       CTRL_W   = 8;
   localparam logic [CTRL_W-1:0] CTRL_RST = 8'h40;
   localparam int unsigned       CNT_W    = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;
   logic              cnt_clr;
   logic [CNT_W-1:0]  stall_cnt;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   logic [127:0] exp_out;
   logic [127:0] next_in;
   logic         acc;
   logic         em;

   always #5 clk = ~clk;

   pipe_stage_reg #(
      .DATA_W  (DATA_W),
      .CTRL_W  (CTRL_W),
      .CTRL_RST(CTRL_RST),
      .CNT_W   (CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush_i    (flush),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready),
      .in_data_i  (in_data),
      .in_ctrl_i  (in_ctrl),
      .out_valid_o(out_valid),
      .out_ready_i(out_ready),
      .out_data_o (out_data),
      .out_ctrl_o (out_ctrl),
      .cnt_clr_i  (cnt_clr),
      .stall_cnt_o(stall_cnt)
   );

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
      out_ready = 1'b0; cnt_clr = 1'b0;

      // reset state
      @(negedge clk); #1;
      check_eq("rst_valid", out_valid, 0);
      check_eq("rst_data", out_data, 0);
      check_eq("rst_ctrl", out_ctrl, CTRL_RST);
      check_eq("rst_cnt", stall_cnt, 0);
      check_eq("rst_ready", in_ready, 1);

      // first transfer, 1-cycle latency
      rst_n = 1'b1; in_valid = 1'b1; in_data = {16{8'hA5}}; in_ctrl = 8'h13; out_ready = 1'b1;
      #1;
      check_eq("t1_ready_pre", in_ready, 1);
      @(negedge clk);
      check_eq("t1_valid", out_valid, 1);
      check_eq("t1_data", out_data, {16{8'hA5}});
      check_eq("t1_ctrl", out_ctrl, 8'h13);
      check_eq("t1_ready", in_ready, 1);
      in_valid = 1'b0;
      @(negedge clk); #1;
      check_eq("t1_bubble_valid", out_valid, 0);
      check_eq("t1_bubble_ctrl", out_ctrl, CTRL_RST);
      check_eq("t1_bubble_data", out_data, {16{8'hA5}});

      // stream 1..8 with out_ready low on cycles 3-5
      exp_out = 1; next_in = 1;
      for (int c = 0; c < 40 && exp_out <= 8; c++) begin
         out_ready = !(c >= 3 && c <= 5);
         in_valid  = (next_in <= 8);
         in_data   = next_in;
         in_ctrl   = next_in[7:0];
         #1;
         if (out_valid) begin
            check_eq("stream_data", out_data, exp_out);
            check_eq("stream_ctrl", out_ctrl, exp_out[7:0]);
         end
         acc = in_valid && in_ready;
         em  = out_valid && out_ready;
         @(negedge clk);
         if (acc) next_in = next_in + 1;
         if (em) exp_out = exp_out + 1;
      end
      in_valid = 1'b0;
      check_eq("stream_done", exp_out, 9);
      check_eq("stream_stall_cnt", stall_cnt, 3);

      // flush while stalled on 0x55
      cnt_clr = 1'b1; out_ready = 1'b0; in_valid = 1'b1; in_data = 128'h55; in_ctrl = 8'h55;
      @(negedge clk);
      cnt_clr = 1'b0;
      check_eq("fl_valid_pre", out_valid, 1);
      check_eq("fl_data_pre", out_data, 128'h55);
      check_eq("fl_cnt_clr", stall_cnt, 0);
      flush = 1'b1; in_data = 128'h66; in_ctrl = 8'h66;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      check_eq("fl_valid", out_valid, 0);
      check_eq("fl_ctrl", out_ctrl, CTRL_RST);
      check_eq("fl_data_hold", out_data, 128'h55);
      check_eq("fl_cnt_kept", stall_cnt, 1);
      out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check_eq("fl_no_emit", out_valid, 0);
      end

      // saturation of the 4-bit stall counter
      out_ready = 1'b0; in_valid = 1'b1; in_data = 128'h77; in_ctrl = 8'h77;
      @(negedge clk);
      in_valid = 1'b0;
      check_eq("sat_valid", out_valid, 1);
      check_eq("sat_cnt_start", stall_cnt, 1);
      repeat (5) @(negedge clk);
      check_eq("sat_cnt_mid", stall_cnt, 6);
      repeat (16) @(negedge clk);
      check_eq("sat_cnt_top", stall_cnt, 15);
      check_eq("sat_data_hold", out_data, 128'h77);
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
      check_eq("sat_cnt_clr", stall_cnt, 0);
      @(negedge clk);
      check_eq("sat_cnt_resume", stall_cnt, 1);

      // asynchronous reset between edges while stalled
      #2 rst_n = 1'b0;
      #1;
      check_eq("arst_valid", out_valid, 0);
      check_eq("arst_ctrl", out_ctrl, CTRL_RST);
      check_eq("arst_data", out_data, 0);
      check_eq("arst_cnt", stall_cnt, 0);
      check_eq("arst_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      check_eq("arst_no_emit", out_valid, 0);
      out_ready = 1'b0;

`ifdef PIPE_STAGE_SKID_EN
      // 1 to main, 2 to skid, 3 held upstream, then drained in order
      in_valid = 1'b1; in_data = 128'h1; in_ctrl = 8'h1;
      #1;
      check_eq("skid_ready0", in_ready, 1);
      @(negedge clk);
      in_data = 128'h2; in_ctrl = 8'h2;
      #1;
      check_eq("skid_main1", out_data, 1);
      check_eq("skid_ready1", in_ready, 1);
      @(negedge clk);
      in_data = 128'h3; in_ctrl = 8'h3;
      #1;
      check_eq("skid_full_ready", in_ready, 0);
      check_eq("skid_full_data", out_data, 1);
      @(negedge clk);
      check_eq("skid_hold_ready", in_ready, 0);
      out_ready = 1'b1;
      #1;
      check_eq("skid_no_comb_path", in_ready, 0);
      check_eq("skid_out1", out_data, 1);
      @(negedge clk);
      check_eq("skid_out2", out_data, 2);
      check_eq("skid_out2_valid", out_valid, 1);
      check_eq("skid_ready_back", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      check_eq("skid_out3", out_data, 3);
      check_eq("skid_out3_ctrl", out_ctrl, 8'h3);
      check_eq("skid_out3_valid", out_valid, 1);
      @(negedge clk);
      check_eq("skid_empty_valid", out_valid, 0);
      check_eq("skid_empty_ctrl", out_ctrl, CTRL_RST);
`else
      // combinational ready and same-cycle replace
      in_valid = 1'b1; in_data = 128'h1; in_ctrl = 8'h1;
      @(negedge clk); #1;
      check_eq("base_valid", out_valid, 1);
      check_eq("base_stall_ready", in_ready, 0);
      out_ready = 1'b1;
      #1;
      check_eq("base_comb_ready", in_ready, 1);
      in_data = 128'h2; in_ctrl = 8'h2;
      @(negedge clk);
      in_valid = 1'b0;
      check_eq("base_replace_data", out_data, 2);
      check_eq("base_replace_valid", out_valid, 1);
      @(negedge clk);
      check_eq("base_drain_valid", out_valid, 0);
      check_eq("base_drain_ctrl", out_ctrl, CTRL_RST);
      check_eq("base_drain_data", out_data, 2);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
